// File: rtl/axi4_lite_cmd_mgr.sv
// Single-outstanding AXI4-Lite manager: turns a valid/ready command/response port into AXI4-Lite transactions.
// Define AXIL_MGR_TIMEOUT_EN to add a per-phase watchdog and the sticky timeout_flag output.
module axi4_lite_cmd_mgr #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_write,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
`ifdef AXIL_MGR_TIMEOUT_EN
  ,
  output logic                    timeout_flag
`endif
);

  localparam int STRB_W = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2 || (DATA_WIDTH != 32 && DATA_WIDTH != 64)) begin : g_bad_param
    $error("axi4_lite_cmd_mgr: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_write_q, rsp_write_d;

`ifdef AXIL_MGR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;
  assign timeout_flag = timeout_flag_q;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W retire independently; a phase already retired ignores further readies
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXIL_MGR_TIMEOUT_EN
    // A phase that is still waiting on its last permitted cycle is abandoned with DECERR
    timeout_flag_d = timeout_flag_q;
    tmo_cnt_d      = tmo_cnt_q + 1'b1;
    if (state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA} && state_d == state_q &&
        tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      awvalid_d      = 1'b0;
      wvalid_d       = 1'b0;
      bready_d       = 1'b0;
      arvalid_d      = 1'b0;
      rready_d       = 1'b0;
      rsp_resp_d     = 2'b11;
      rsp_rdata_d    = '0;
      rsp_valid_d    = 1'b1;
      timeout_flag_d = 1'b1;
      state_d        = RSP;
    end
    if (state_d != state_q) tmo_cnt_d = '0;
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      rsp_write_q <= 1'b0;
`ifdef AXIL_MGR_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_write_q <= rsp_write_d;
`ifdef AXIL_MGR_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_write     = rsp_write_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mgr.sv
// Bench for axi4_lite_cmd_mgr: directed commands against an 8-register subordinate model, scoreboarded responses.
module tb_axi4_lite_cmd_mgr;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef AXIL_MGR_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic          aclk, areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
`ifdef AXIL_MGR_TIMEOUT_EN
  logic          timeout_flag;
`endif

  axi4_lite_cmd_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
`ifdef AXIL_MGR_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t sb[$];

  // Response monitor: samples just after the falling edge, once the stimulus has settled
  always @(negedge aclk) begin
    rsp_t e;
    #1;
    if (!areset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 resp=%0h want no response", rsp_resp);
      end else begin
        e = sb.pop_front();
        check("rsp_write", rsp_write, e.wr);
        check("rsp_resp", rsp_resp, e.resp);
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // Subordinate model: 8 registers at 0x00..0x1C; handshakes seen at one falling edge
  // take effect at the following falling edge.
  logic [31:0] regs [8];
  int          w_wait = 0, b_wait = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  bit          ar_en = 1'b1;
  bit          aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
  bit          aw_got, w_got, b_pend, ar_pend;
  int          w_cnt, b_cnt;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  always @(negedge aclk) begin
    if (areset) begin
      {aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p} = '0;
      {aw_got, w_got, b_pend, ar_pend} = '0;
      w_cnt = 0;
      b_cnt = 0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_rvalid  = 1'b0;
    end else begin
      if (aw_hs_p) aw_got = 1'b1;
      if (w_hs_p)  w_got  = 1'b1;
      if (b_hs_p)  m_axi_bvalid = 1'b0;
      if (r_hs_p)  m_axi_rvalid = 1'b0;
      if (ar_hs_p) ar_pend = 1'b1;
      if (aw_got && w_got) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) regs[s_awaddr[4:2]][8*i +: 8] = s_wdata[8*i +: 8];
        aw_got = 1'b0;
        w_got  = 1'b0;
        b_pend = 1'b1;
        b_cnt  = 0;
      end
      if (b_pend) begin
        if (b_cnt >= b_wait) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = b_resp_cfg;
          b_pend       = 1'b0;
        end else b_cnt++;
      end
      if (ar_pend) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = regs[s_araddr[4:2]];
        m_axi_rresp  = 2'b00;
        ar_pend      = 1'b0;
      end
      m_axi_awready = 1'b1;
      if (m_axi_wvalid) begin
        m_axi_wready = (w_cnt >= w_wait);
        w_cnt++;
      end else begin
        m_axi_wready = 1'b0;
        w_cnt = 0;
      end
      m_axi_arready = m_axi_arvalid && ar_en;
      aw_hs_p = m_axi_awvalid && m_axi_awready;
      w_hs_p  = m_axi_wvalid && m_axi_wready;
      b_hs_p  = m_axi_bvalid && m_axi_bready;
      ar_hs_p = m_axi_arvalid && m_axi_arready;
      r_hs_p  = m_axi_rvalid && m_axi_rready;
      if (aw_hs_p) s_awaddr = m_axi_awaddr;
      if (w_hs_p) begin
        s_wdata = m_axi_wdata;
        s_wstrb = m_axi_wstrb;
      end
      if (ar_hs_p) s_araddr = m_axi_araddr;
    end
  end

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 after %0d cycles want 1", n);
    end
    @(posedge aclk);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cmd_ready && !rsp_valid && sb.size() == 0) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got pending=%0d cmd_ready=%0b want 0 and 1", sb.size(), cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) regs[i] = 32'h0;
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    m_axi_bresp = 2'b00; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    repeat (2) @(negedge aclk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 6'b0);
    check("reset_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
    check("reset_payload", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 68'h0);
`ifdef AXIL_MGR_TIMEOUT_EN
    check("reset_timeout_flag", timeout_flag, 1'b0);
`endif
    areset = 1'b0;
    @(negedge aclk);

    // Zero-wait write 0x04 <- DEADBEEF with latency checks
    sb.push_back('{1'b1, 2'b00, 32'h0});
    send(1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
    check("wr_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    check("wr_awaddr", m_axi_awaddr, 32'h04);
    check("wr_wdata", m_axi_wdata, 32'hDEADBEEF);
    check("wr_wstrb", m_axi_wstrb, 4'hF);
    @(negedge aclk);
    check("wr_after_aw_w", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    @(negedge aclk);
    check("wr_rsp_valid_t3", {rsp_valid, rsp_write}, 2'b11);
    wait_idle();
    check("wr_reg1", regs[1], 32'hDEADBEEF);
    sb.push_back('{1'b0, 2'b00, 32'hDEADBEEF});
    send(1'b0, 32'h04, 32'h0, 4'h0);
    wait_idle();

    // Write then read 0x1C
    sb.push_back('{1'b1, 2'b00, 32'h0});
    send(1'b1, 32'h1C, 32'h12345678, 4'hF);
    wait_idle();
    sb.push_back('{1'b0, 2'b00, 32'h12345678});
    send(1'b0, 32'h1C, 32'h0, 4'h0);
    check("rd_arvalid", m_axi_arvalid, 1'b1);
    check("rd_araddr", m_axi_araddr, 32'h1C);
    @(negedge aclk);
    check("rd_after_ar", {m_axi_arvalid, m_axi_rready}, 2'b01);
    @(negedge aclk);
    check("rd_rsp_valid_t3", {rsp_valid, rsp_write}, 2'b10);
    wait_idle();

    // wready lags awready by 5 cycles; byte strobes 0x3
    w_wait = 5;
    sb.push_back('{1'b1, 2'b00, 32'h0});
    send(1'b1, 32'h00, 32'h0BADF00D, 4'h3);
    for (int k = 0; k < 6; k++) begin
      check("dly_awvalid", m_axi_awvalid, (k == 0));
      check("dly_wvalid_wdata", {m_axi_wvalid, m_axi_wdata}, {1'b1, 32'h0BADF00D});
      @(negedge aclk);
    end
    check("dly_wvalid_drop", m_axi_wvalid, 1'b0);
    wait_idle();
    w_wait = 0;
    check("dly_reg0_strobed", regs[0], 32'h0000F00D);

    // Response back-pressure with SLVERR
    b_wait = 3;
    b_resp_cfg = 2'b10;
    rsp_ready = 1'b0;
    sb.push_back('{1'b1, 2'b10, 32'h0});
    send(1'b1, 32'h08, 32'h11111111, 4'hF);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", {rsp_valid, rsp_resp, cmd_ready}, 4'b1100);
      @(negedge aclk);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
    check("bp_no_accept", cmd_ready, 1'b0);
    sb.push_back('{1'b0, 2'b00, 32'h11111111});
    rsp_ready = 1'b1;
    send(1'b0, 32'h08, 32'h0, 4'h0);
    wait_idle();
    b_wait = 0;
    b_resp_cfg = 2'b00;

    // Reset while waiting for arready
    ar_en = 1'b0;
    send(1'b0, 32'h10, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      check("rst_arvalid_wait", m_axi_arvalid, 1'b1);
      @(negedge aclk);
    end
    areset = 1'b1;
    #1;
    check("rst_async", {m_axi_arvalid, rsp_valid, cmd_ready}, 3'b001);
    @(negedge aclk);
    areset = 1'b0;
    ar_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("rst_after", {rsp_valid, cmd_ready}, 2'b01);
      @(negedge aclk);
    end
    sb.push_back('{1'b0, 2'b00, 32'h0000F00D});
    send(1'b0, 32'h00, 32'h0, 4'h0);
    check("rst_read_araddr", m_axi_araddr, 32'h00);
    wait_idle();

`ifdef AXIL_MGR_TIMEOUT_EN
    // arready never arrives: watchdog aborts with DECERR
    ar_en = 1'b0;
    sb.push_back('{1'b0, 2'b11, 32'h0});
    send(1'b0, 32'h14, 32'h0, 4'h0);
    n = 0;
    while (m_axi_arvalid && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("tmo_arvalid_cycles", n, 16);
    check("tmo_rsp", {rsp_valid, rsp_resp, timeout_flag}, 4'b1111);
    wait_idle();
    ar_en = 1'b1;
    check("tmo_flag_sticky", timeout_flag, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_lite_cmd_mgr.md
Name: axi4_lite_cmd_mgr

Overview:
- Single-outstanding AXI4-Lite manager.
- Converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions.
- Sits directly upstream of the register-file subordinate: its m_axi_* outputs drive that block's AW/W/B/AR/R channels.
- Used by test sequencers and CPU-less control logic to program the 8-register space at 0x00..0x1C.

Parameters:
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- ADDR_WIDTH, 32, AXI address width.
- TIMEOUT_CYCLES, 256, watchdog limit per AXI phase; only used when AXIL_MGR_TIMEOUT_EN is defined; must be >= 2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address; passed through unmodified.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI response code.
- rsp_write  out  1  echo of cmd_write.
- m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid  out  AW channel; m_axi_awready  in.
- m_axi_wdata, m_axi_wstrb, m_axi_wvalid  out  W channel; m_axi_wready  in.
- m_axi_bresp(2)  in, m_axi_bvalid  in, m_axi_bready  out  B channel.
- m_axi_araddr, m_axi_arprot(3), m_axi_arvalid  out  AR channel; m_axi_arready  in.
- m_axi_rdata, m_axi_rresp(2), m_axi_rvalid  in, m_axi_rready  out  R channel.

Behaviour:
- Reset (areset=1, async):
  - State = IDLE; cmd_ready=1.
  - All m_axi_*valid/ready outputs = 0; all address/data outputs = 0.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_write=0.
  - Reset mid-transaction abandons it; no response is produced.
- All outputs are registered. awprot/arprot are fixed 3'b000.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch addr/wdata/wstrb/write; cmd_ready<=0.
  - Write: awvalid<=1 and wvalid<=1 in the same cycle -> WR.
  - Read: arvalid<=1 -> RD_ADDR.
  - First AXI valid is visible the cycle after the accept edge.
- WR:
  - AW and W complete independently. awvalid drops on the edge where awready=1; wvalid drops on the edge where wready=1.
  - Each phase completes once; a repeated ready is ignored.
  - When both have completed (possibly the same edge): bready<=1 -> WR_RESP.
- WR_RESP: on bvalid & bready, latch bresp, bready<=0, rsp_rdata<=0 -> RSP.
- RD_ADDR: on arready, arvalid<=0, rready<=1 -> RD_DATA.
- RD_DATA: on rvalid & rready, latch rdata/rresp, rready<=0 -> RSP.
- RSP:
  - rsp_valid=1; response held stable until rsp_ready.
  - On handshake: rsp_valid<=0, cmd_ready<=1 -> IDLE.
  - The next command cannot be accepted in the same cycle as the response handshake. Minimum issue interval is 1 cycle after response.
- Protocol rules:
  - A valid, once asserted, is never deasserted before its ready.
  - No valid depends combinationally on any ready.
  - Channel payloads are stable while valid is asserted.
  - A subordinate holding awready/wready/arready=1 before valid is legal: a handshake occurs on the first valid cycle.
- Latency, zero-wait subordinate:
  - Write: accept edge T, AW/W handshake T+1, B handshake T+2, rsp_valid at T+3.
  - Read: accept T, AR T+1, R T+2, rsp_valid at T+3.
- Unexpected bvalid/rvalid outside WR_RESP/RD_DATA is ignored (ready=0).

Optional Feature:
- Macro: AXIL_MGR_TIMEOUT_EN.
- Defined:
  - A per-phase cycle counter is reset at entry to WR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES with the phase incomplete: all m_axi valids/readies <= 0, rsp_resp <= 2'b11 (DECERR), rsp_rdata <= 0 -> RSP.
  - Sticky output port timeout_flag (out, 1, reset 0) sets; it clears only on reset.
  - The abort knowingly violates AXI. It exists for bring-up against hung subordinates.
- Undefined: no counter, no timeout_flag port; the FSM waits indefinitely.

Test Plan:
- Write 0x04 <- 0xDEADBEEF, wstrb 0xF, zero-wait subordinate -> AW/W handshake at T+1, rsp_valid at T+3 with rsp_resp=00, rsp_write=1; subordinate register 1 reads back 0xDEADBEEF.
- Read 0x1C after writing 0x12345678 -> araddr=0x1C, rsp_rdata=0x12345678, rsp_resp=00, rsp_write=0.
- Write with wready delayed 5 cycles after awready -> awvalid drops after 1 cycle, wvalid held with stable wdata for 6 cycles, single response returned.
- rsp_ready held 0 for 10 cycles, then bvalid returns bresp=10 -> rsp_valid held, rsp_resp=10 stable, cmd_ready=0 throughout; the next cmd is accepted only after the rsp handshake.
- areset pulsed while arvalid=1 and awaiting arready -> arvalid=0 immediately, no rsp_valid, cmd_ready=1 after release; a subsequent read of 0x00 completes normally.
- With AXIL_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready never asserted -> arvalid drops at cycle 16, rsp_resp=11, rsp_rdata=0, timeout_flag=1.
